// File: rtl/seg_scan_driver.sv
// Two-value (00..99) multiplexed 4-digit seven-segment driver.
// Both binary inputs are converted to BCD in parallel by double-dabble.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] hi_val,
    input  logic [6:0] lo_val,
    input  logic       load,
    input  logic       blank,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t          state;
    logic [2:0]      iter;
    logic [14:0]     hi_sr, lo_sr;
    logic            pend;
    logic [6:0]      pend_hi, pend_lo;
    logic [6:0]      start_hi, start_lo;
    logic [3:0][3:0] digits;
    logic [CNT_W-1:0] presc;
    logic [1:0]      idx;
    logic [3:0]      an_n;
    logic [6:0]      seg_n;
    logic            dp_n;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // One add-3/shift step; sr = {tens, units, remaining binary bits}
    function automatic logic [14:0] dabble(input logic [14:0] sr);
        logic [14:0] t;
        t = sr;
        if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // A load coinciding with the UPDATE edge is newer than the pending slot
    always_comb begin
        start_hi = load ? hi_val : pend_hi;
        start_lo = load ? lo_val : pend_lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            iter    <= '0;
            hi_sr   <= '0;
            lo_sr   <= '0;
            pend    <= 1'b0;
            pend_hi <= '0;
            pend_lo <= '0;
            digits  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        hi_sr <= {8'd0, clamp99(hi_val)};
                        lo_sr <= {8'd0, clamp99(lo_val)};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    hi_sr <= dabble(hi_sr);
                    lo_sr <= dabble(lo_sr);
                    iter  <= iter + 3'd1;
                    if (iter == 3'd6) state <= UPDATE;
                    if (load) begin
                        pend    <= 1'b1;
                        pend_hi <= hi_val;
                        pend_lo <= lo_val;
                    end
                end
                UPDATE: begin
                    digits <= {hi_sr[14:11], hi_sr[10:7], lo_sr[14:11], lo_sr[10:7]};
                    pend   <= 1'b0;
                    if (load || pend) begin
                        hi_sr <= {8'd0, clamp99(start_hi)};
                        lo_sr <= {8'd0, clamp99(start_lo)};
                        iter  <= '0;
                        state <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        an_n  = ~(4'b0001 << idx);
        seg_n = seg_decode(digits[idx]);
        dp_n  = (idx != 2'd2);
        if (LZ_BLANK != 0 && idx == 2'd3 && digits[3] == 4'd0) begin
            an_n  = '1;
            seg_n = '1;
        end
        if (blank) begin
            an_n  = '1;
            seg_n = '1;
            dp_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
            an    <= 4'b1110;
            seg   <= 7'b1000000;
            dp    <= 1'b1;
        end else begin
            if (presc == CNT_W'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + CNT_W'(1);
            end
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot (>=2).
REQ-002 SHALL have parameter LZ_BLANK, default 1: 1 = blank the hi tens digit when it is 0.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hi_val  input  7  upper counter value, binary.
REQ-006 SHALL have port lo_val  input  7  lower counter value, binary.
REQ-007 SHALL have port load  input  1  single-cycle strobe; sample hi_val/lo_val.
REQ-008 SHALL have port blank  input  1  force the display dark.
REQ-009 SHALL have port busy  output  1  BCD conversion in progress.
REQ-010 SHALL have port an  output  4  digit enables, active-low; an[0]=lo units, an[3]=hi tens.
REQ-011 SHALL have port seg  output  7  segments, active-low; seg[0]=a .. seg[6]=g.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-013 SHALL clamp each sampled value >99 to 99 before conversion.
REQ-014 SHALL implement FSM IDLE -> CONV -> UPDATE -> IDLE.
- IDLE: load=1 -> CONV (values captured at the same edge E0).
REQ-015 SHALL perform one shift-add-3 iteration per cycle in CONV on both values in parallel, 7 iterations total (E1..E7), then -> UPDATE.
REQ-016 SHALL write the four display digit registers at E8 in UPDATE, then -> IDLE.
REQ-017 SHALL drive busy=1 from after E0 through E8 inclusive (8 cycles) and 0 otherwise.
REQ-018 SHALL keep showing the old digits until E8.
- Load while busy SHALL capture the values into a single pending slot; a later load overwrites that slot.
REQ-019 SHALL start a new conversion from the pending slot at the edge after UPDATE, without passing through IDLE, if a pending request exists; busy stays 1.
REQ-020 SHALL treat load at the UPDATE edge as pending, not lost.
REQ-021 SHALL run a prescaler 0..REFRESH_DIV-1 that wraps.
- On wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-022 SHALL drive one an bit low per index (index0 -> 4'b1110, index3 -> 4'b0111) and seg with that digit's pattern; '0' = 7'b1000000.
REQ-023 SHALL drive dp=0 only while index=2 (hi units, separator) and 1 otherwise.
REQ-024 SHALL, when LZ_BLANK=1 and the hi tens digit is 0, drive an=4'b1111 and seg=7'b1111111 during slot 3.
REQ-025 SHALL, when blank=1, drive an=4'b1111, seg=7'b1111111 and dp=1.
- Prescaler, scan and FSM SHALL continue unaffected.
REQ-026 SHALL register an, seg and dp; these outputs change one cycle after the index changes.

Reset
REQ-027 SHALL, on reset (asynchronous, any cycle including mid-CONV), immediately set:
- state IDLE, pending cleared, busy=0;
- all digits 0, prescaler 0, index 0;
- an=4'b1110, seg=7'b1000000, dp=1.
REQ-028 SHALL discard any in-flight or pending conversion on reset.

Verification
REQ-029 SHALL verify REFRESH_DIV=4, load hi=12 lo=34 -> busy high exactly 8 cycles; then an 1110/1101/1011/0111 show 4/3/2/1, each held 4 cycles, with dp=0 only while an=1011.
REQ-030 SHALL verify load hi=5 lo=7, LZ_BLANK=1 -> slot 3 is dark (an=1111); slot 2 shows 5 with seg=7'b0010010.
REQ-031 SHALL verify load lo=127 hi=100 -> all four digits display 9 (seg=7'b0010000).
REQ-032 SHALL verify load A=(1,1) then, while busy, B=(2,2) and C=(3,3) -> A appears, busy stays high, then C (3,3) appears; B is never displayed.
REQ-033 SHALL verify assert reset 3 cycles into CONV -> busy=0 immediately, an=1110, seg=1000000; no update follows.
REQ-034 SHALL verify blank=1 for 10 cycles -> an=1111, seg=1111111, dp=1; on release, scan resumes at the index it reached.
